oclib_bc_buffer: RTL and testbench

OCLIB_BC_BUFFER -- requirements
Module: oclib_bc_buffer

---
 rtl/oclib_pkg.sv | 10 +
 rtl/oclib_bc_buffer_lane.sv | 61 ++++++
 rtl/oclib_bc_buffer.sv | 75 +++++++
 tb/tb_oclib_bc_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// Shared byte-channel types for the oclib blocks.
package oclib_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ready;
  } bc_8b_bidi_s;

endpackage

// File: rtl/oclib_bc_buffer_lane.sv
// One direction of the byte-channel buffer: pulsed-ready accept into a small
// FIFO, followed by a registered output word that is held until the sink's ready.
module oclib_bc_buffer_lane #(
  parameter int DATA_W = 8,
  parameter int Depth  = 4,
  localparam int PTR_W = $clog2(Depth),
  localparam int CNT_W = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [Depth];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Fullness is judged on the pre-pop count, so a pop never frees a slot for
  // an accept at the same edge; !in_ready keeps the ready strictly one-cycle.
  assign push = in_valid && !in_ready && (count < CNT_W'(Depth));
  assign pop  = !out_valid && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready <= push;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/oclib_bc_buffer.sv
// Bidirectional byte-channel buffer: an independent request lane (up -> down)
// and response lane (down -> up), each with a Depth-entry FIFO.
module oclib_bc_buffer
  import oclib_pkg::*;
#(
  parameter type BcType = oclib_pkg::bc_8b_bidi_s,
  parameter int  Depth  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  BcType                      upIn,
  output BcType                      upOut,
  output BcType                      downOut,
  input  BcType                      downIn,
  output logic [$clog2(Depth+1)-1:0] reqCount,
  output logic [$clog2(Depth+1)-1:0] respCount
);

  // The channel struct carries one data field plus the valid and ready bits.
  localparam int DATA_W = $bits(BcType) - 2;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("oclib_bc_buffer: Depth must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] req_data;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_valid;
  logic              resp_ready;

  oclib_bc_buffer_lane #(
    .DATA_W (DATA_W),
    .Depth  (Depth)
  ) u_req_lane (
    .clk       (clock),
    .rst_n     (reset),
    .in_data   (upIn.data),
    .in_valid  (upIn.valid),
    .in_ready  (req_ready),
    .out_data  (req_data),
    .out_valid (req_valid),
    .out_ready (downIn.ready),
    .count     (reqCount)
  );

  oclib_bc_buffer_lane #(
    .DATA_W (DATA_W),
    .Depth  (Depth)
  ) u_resp_lane (
    .clk       (clock),
    .rst_n     (reset),
    .in_data   (downIn.data),
    .in_valid  (downIn.valid),
    .in_ready  (resp_ready),
    .out_data  (resp_data),
    .out_valid (resp_valid),
    .out_ready (upIn.ready),
    .count     (respCount)
  );

  // Each lane's accept ready travels back in the opposite-direction struct.
  always_comb begin
    upOut         = '0;
    upOut.data    = resp_data;
    upOut.valid   = resp_valid;
    upOut.ready   = req_ready;
    downOut       = '0;
    downOut.data  = req_data;
    downOut.valid = req_valid;
    downOut.ready = resp_ready;
  end

endmodule

// File: tb/tb_oclib_bc_buffer.sv
// Directed bench for oclib_bc_buffer (Depth=4, 8-bit byte channel).
module tb_oclib_bc_buffer;
  import oclib_pkg::*;

  localparam int TMO = 200;

  logic        clock;
  logic        reset;
  bc_8b_bidi_s upIn;
  bc_8b_bidi_s upOut;
  bc_8b_bidi_s downOut;
  bc_8b_bidi_s downIn;
  logic [2:0]  reqCount;
  logic [2:0]  respCount;

  logic [7:0]  req_data;
  logic        req_valid;
  logic        up_ready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        dn_ready;

  int n_cmp;
  int n_err;

  oclib_bc_buffer #(
    .BcType (bc_8b_bidi_s),
    .Depth  (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .upIn      (upIn),
    .upOut     (upOut),
    .downOut   (downOut),
    .downIn    (downIn),
    .reqCount  (reqCount),
    .respCount (respCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    upIn         = '0;
    upIn.data    = req_data;
    upIn.valid   = req_valid;
    upIn.ready   = up_ready;
    downIn       = '0;
    downIn.data  = resp_data;
    downIn.valid = resp_valid;
    downIn.ready = dn_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // lane 0 = request (up -> down), lane 1 = response (down -> up)
  function automatic logic acc(input int lane);
    return (lane == 0) ? upOut.ready : downOut.ready;
  endfunction

  function automatic logic out_v(input int lane);
    return (lane == 0) ? downOut.valid : upOut.valid;
  endfunction

  function automatic logic [7:0] out_d(input int lane);
    return (lane == 0) ? downOut.data : upOut.data;
  endfunction

  task automatic send(input int lane, input logic [7:0] d, input string tag);
    int n;
    n = 0;
    if (lane == 0) begin req_data = d; req_valid = 1'b1; end
    else begin resp_data = d; resp_valid = 1'b1; end
    do begin
      @(negedge clock);
      n++;
    end while (!acc(lane) && n < TMO);
    check({tag, "_acc"}, 32'(acc(lane)), 32'd1);
    if (lane == 0) req_valid = 1'b0;
    else resp_valid = 1'b0;
  endtask

  task automatic recv(input int lane, input logic [7:0] exp, input string tag, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clock);
    while (!out_v(lane) && n < TMO) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_vld"}, 32'(out_v(lane)), 32'd1);
    check(tag, 32'(out_d(lane)), 32'(exp));
    if (lane == 0) dn_ready = 1'b1;
    else up_ready = 1'b1;
    @(negedge clock);
    if (lane == 0) dn_ready = 1'b0;
    else up_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    req_data   = '0;
    req_valid  = 1'b0;
    up_ready   = 1'b0;
    resp_data  = '0;
    resp_valid = 1'b0;
    dn_ready   = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_upOut", 32'(upOut), 32'd0);
    check("rst_downOut", 32'(downOut), 32'd0);
    check("rst_reqCount", 32'(reqCount), 32'd0);
    check("rst_respCount", 32'(respCount), 32'd0);
    reset = 1'b1;

    // Single word: accept edge ends cycle 0, ready in cycle 1, valid in cycle 2
    req_data  = 8'h5A;
    req_valid = 1'b1;
    @(negedge clock);
    check("single_ready", 32'(upOut.ready), 32'd1);
    check("single_cnt1", 32'(reqCount), 32'd1);
    check("single_novld", 32'(downOut.valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clock);
    check("single_ready_pulse", 32'(upOut.ready), 32'd0);
    check("single_vld", 32'(downOut.valid), 32'd1);
    check("single_data", 32'(downOut.data), 32'h5A);
    check("single_cnt0", 32'(reqCount), 32'd0);
    dn_ready = 1'b1;
    @(negedge clock);
    dn_ready = 1'b0;
    check("single_clr", 32'(downOut.valid), 32'd0);
    check("single_hold", 32'(downOut.data), 32'h5A);

    // Fill: five accepted (four in FIFO, one in output register)
    for (int i = 1; i <= 5; i++) send(0, 8'(i), "fill");
    check("fill_cnt", 32'(reqCount), 32'd4);
    check("fill_vld", 32'(downOut.valid), 32'd1);
    check("fill_head", 32'(downOut.data), 32'h01);
    req_data  = 8'h06;
    req_valid = 1'b1;
    seen      = 1'b0;
    repeat (8) begin
      @(negedge clock);
      seen = seen | upOut.ready;
    end
    check("fill_noacc", 32'(seen), 32'd0);
    check("fill_cnt_hold", 32'(reqCount), 32'd4);

    // Full with pop: the freed output register refills first; accept comes after
    dn_ready = 1'b1;
    @(negedge clock);
    dn_ready = 1'b0;
    check("fullpop_noacc0", 32'(upOut.ready), 32'd0);
    check("fullpop_cnt0", 32'(reqCount), 32'd4);
    check("fullpop_clr", 32'(downOut.valid), 32'd0);
    @(negedge clock);
    check("fullpop_noacc1", 32'(upOut.ready), 32'd0);
    check("fullpop_cnt1", 32'(reqCount), 32'd3);
    check("fullpop_vld", 32'(downOut.valid), 32'd1);
    check("fullpop_data", 32'(downOut.data), 32'h02);
    @(negedge clock);
    check("fullpop_acc", 32'(upOut.ready), 32'd1);
    check("fullpop_cnt2", 32'(reqCount), 32'd4);
    req_valid = 1'b0;
    for (int i = 2; i <= 6; i++) recv(0, 8'(i), "fill_order", 1);
    check("fill_empty", 32'(reqCount), 32'd0);

    // Wrap: 20 words through a 4-entry FIFO with random sink gaps
    fork
      begin
        for (int i = 0; i < 20; i++) send(0, 8'h10 + 8'(i), "wrap_tx");
      end
      begin
        for (int i = 0; i < 20; i++) recv(0, 8'h10 + 8'(i), "wrap_rx", int'($urandom_range(0, 3)));
      end
    join
    check("wrap_empty", 32'(reqCount), 32'd0);

    // Bidirectional: both lanes at once
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 8'hA0 + 8'(i), "bidi_req_tx");
      end
      begin
        for (int i = 0; i < 8; i++) recv(0, 8'hA0 + 8'(i), "bidi_req_rx", i % 3);
      end
      begin
        for (int i = 0; i < 8; i++) send(1, 8'hB0 + 8'(i), "bidi_resp_tx");
      end
      begin
        for (int i = 0; i < 8; i++) recv(1, 8'hB0 + 8'(i), "bidi_resp_rx", (i + 1) % 2);
      end
    join
    check("bidi_req_empty", 32'(reqCount), 32'd0);
    check("bidi_resp_empty", 32'(respCount), 32'd0);

    // Async reset with reqCount=3 and an output word pending
    for (int i = 0; i < 4; i++) send(0, 8'h31 + 8'(i), "rst_fill");
    check("prerst_cnt", 32'(reqCount), 32'd3);
    check("prerst_vld", 32'(downOut.valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_upOut", 32'(upOut), 32'd0);
    check("arst_downOut", 32'(downOut), 32'd0);
    check("arst_reqCount", 32'(reqCount), 32'd0);
    check("arst_respCount", 32'(respCount), 32'd0);
    repeat (2) @(negedge clock);
    reset     = 1'b1;
    req_data  = 8'h77;
    req_valid = 1'b1;
    @(negedge clock);
    check("post_rst_acc", 32'(upOut.ready), 32'd1);
    check("post_rst_cnt", 32'(reqCount), 32'd1);
    check("post_rst_novld", 32'(downOut.valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clock);
    check("post_rst_vld", 32'(downOut.valid), 32'd1);
    check("post_rst_data", 32'(downOut.data), 32'h77);
    check("post_rst_cnt0", 32'(reqCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
